// File: rtl/video_scene_sequencer.sv
// Frame-synchronous test-scene sequencer feeding the hdmi_vga rgb input.
// Optional: define SCENE_BORDER_EN to overlay a 1-px white border.
module video_scene_sequencer #(
   parameter int NUM_SCENES  = 4,
   parameter int HOLD_FRAMES = 60,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  sx,
   input  logic [9:0]  sy,
   input  logic        auto_en,
   input  logic        req_valid,
   input  logic [1:0]  req_scene,
   output logic        req_ready,
   output logic [1:0]  scene,
   output logic        frame_start,
   output logic [7:0]  frame_cnt,
   output logic [23:0] rgb
);

   localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES);

   typedef enum logic {RUN, PENDING} state_t;

   state_t         state;
   logic [1:0]     pending;
   logic [HW-1:0]  hold;
   logic           prev_at0;

   logic           at0;
   logic           boundary;
   logic [1:0]     scene_nxt;
   logic [HW-1:0]  hold_nxt;
   logic [9:0]     bar_idx;
   logic [23:0]    pix;

   always_comb begin
      at0       = (sx == 10'd0) && (sy == 10'd0);
      boundary  = at0 && !prev_at0;
      scene_nxt = scene;
      hold_nxt  = hold;
      if (boundary) begin
         // A latched manual request always beats auto-advance.
         if (state == PENDING) begin
            scene_nxt = pending;
            hold_nxt  = '0;
         end else if (auto_en) begin
            if (hold == HW'(HOLD_FRAMES - 1)) begin
               hold_nxt  = '0;
               scene_nxt = (scene == 2'(NUM_SCENES - 1)) ? 2'd0
                                                         : scene + 2'd1;
            end else begin
               hold_nxt = hold + HW'(1);
            end
         end
      end
   end

   // Render from scene_nxt so the first pixel of a frame shows the new scene.
   always_comb begin
      bar_idx = sx / 10'd80;
      pix     = 24'h000000;
      case (scene_nxt)
         2'd0: pix = 24'h0000FF;
         2'd1: begin
            if (sx >= 10'd100 && sx < 10'd540 &&
                sy >= 10'd100 && sy < 10'd380)
               pix = 24'hFFFFFF;
            else
               pix = 24'h0000FF;
         end
         2'd2: begin
            if (sx < 10'd640) begin
               case (bar_idx[2:0])
                  3'd0: pix = 24'hFFFFFF;
                  3'd1: pix = 24'hFFFF00;
                  3'd2: pix = 24'h00FFFF;
                  3'd3: pix = 24'h00FF00;
                  3'd4: pix = 24'hFF00FF;
                  3'd5: pix = 24'hFF0000;
                  3'd6: pix = 24'h0000FF;
                  default: pix = 24'h000000;
               endcase
            end
         end
         default: pix = (sx[5] ^ sy[5]) ? 24'hFFFFFF : 24'h000000;
      endcase
`ifdef SCENE_BORDER_EN
      if (sx == 10'd0 || sx == 10'(H_ACTIVE - 1) ||
          sy == 10'd0 || sy == 10'(V_ACTIVE - 1))
         pix = 24'hFFFFFF;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         req_ready   <= 1'b1;
         pending     <= 2'd0;
         hold        <= '0;
         scene       <= 2'd0;
         prev_at0    <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= 8'd0;
         rgb         <= 24'h000000;
      end else begin
         prev_at0    <= at0;
         frame_start <= boundary;
         if (boundary)
            frame_cnt <= frame_cnt + 8'd1;
         scene <= scene_nxt;
         hold  <= hold_nxt;
         rgb   <= pix;
         unique case (state)
            RUN: begin
               if (req_valid && req_ready) begin
                  pending   <= req_scene;
                  state     <= PENDING;
                  req_ready <= 1'b0;
               end
            end
            PENDING: begin
               if (boundary) begin
                  state     <= RUN;
                  req_ready <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_scene_sequencer.sv
// Scoreboard bench for video_scene_sequencer using short synthetic frames.
// Expected pixels are queued on drive and popped one cycle later.
module tb_video_scene_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  sx;
   logic [9:0]  sy;
   logic        auto_en;
   logic        req_valid;
   logic [1:0]  req_scene;
   logic        req_ready;
   logic [1:0]  scene;
   logic        frame_start;
   logic [7:0]  frame_cnt;
   logic [23:0] rgb;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   logic [23:0] q [$];

   localparam logic [23:0] BARS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   video_scene_sequencer #(
      .NUM_SCENES(4), .HOLD_FRAMES(2),
      .H_ACTIVE(640), .V_ACTIVE(480)
   ) dut (
      .clk(clk), .rst(rst), .sx(sx), .sy(sy),
      .auto_en(auto_en), .req_valid(req_valid),
      .req_scene(req_scene), .req_ready(req_ready),
      .scene(scene), .frame_start(frame_start),
      .frame_cnt(frame_cnt), .rgb(rgb)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] ref_rgb(input logic [1:0] s,
                                           input int x, input int y);
      logic [23:0] c;
      case (s)
         2'd0: c = 24'h0000FF;
         2'd1: c = (x >= 100 && x < 540 && y >= 100 && y < 380)
                   ? 24'hFFFFFF : 24'h0000FF;
         2'd2: c = (x >= 640) ? 24'h000000 : BARS[x / 80];
         default: c = ((((x >> 5) ^ (y >> 5)) & 1) == 1)
                      ? 24'hFFFFFF : 24'h000000;
      endcase
`ifdef SCENE_BORDER_EN
      if (x == 0 || x == 639 || y == 0 || y == 479)
         c = 24'hFFFFFF;
`endif
      return c;
   endfunction

   task automatic step(input int x, input int y, input logic [1:0] es,
                       input logic rv = 1'b0,
                       input logic [1:0] rs = 2'd0);
      logic [23:0] e;
      @(negedge clk);
      sx = 10'(x);
      sy = 10'(y);
      req_valid = rv;
      req_scene = rs;
      q.push_back(ref_rgb(es, x, y));
      @(posedge clk);
      #1;
      e = q.pop_front();
      checks++;
      if (rgb !== e) begin
         failures++;
         $display("FAIL rgb(%0d,%0d) got %h exp %h", x, y, rgb, e);
      end
      checks++;
      if (scene !== es) begin
         failures++;
         $display("FAIL scene(%0d,%0d) got %0d exp %0d", x, y, scene, es);
      end
      if (frame_start === 1'b1)
         pulses++;
      req_valid = 1'b0;
   endtask

   task automatic frame(input logic [1:0] s);
      step(0, 0, s);
      step(320, 240, s);
      step(5, 5, s);
      step(639, 479, s);
   endtask

   task automatic chk_ready(input string nm, input logic e);
      checks++;
      if (req_ready !== e) begin
         failures++;
         $display("FAIL %s req_ready got %b exp %b", nm, req_ready, e);
      end
   endtask

   task automatic test_reset(input logic ae);
      @(negedge clk);
      rst = 1'b1;
      sx = 10'd10;
      sy = 10'd10;
      auto_en = 1'b0;
      req_valid = 1'b0;
      req_scene = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (scene !== 2'd0 || rgb !== 24'h0 || frame_start !== 1'b0 ||
          frame_cnt !== 8'd0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset scene=%0d rgb=%h fs=%b cnt=%0d rdy=%b exp 0,0,0,0,1",
                  scene, rgb, frame_start, frame_cnt, req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      auto_en = ae;
      q.delete();
      pulses = 0;
   endtask

   task automatic test_static;
      test_reset(1'b0);
      step(100, 100, 0);
      frame(0);
      frame(0);
      checks++;
      if (frame_cnt !== 8'd2 || pulses != 2) begin
         failures++;
         $display("FAIL static frame_cnt=%0d pulses=%0d exp 2,2", frame_cnt, pulses);
      end
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      checks++;
      if (frame_cnt !== 8'd3 || pulses != 3) begin
         failures++;
         $display("FAIL hold_origin frame_cnt=%0d pulses=%0d exp 3,3", frame_cnt, pulses);
      end
   endtask

   task automatic test_auto;
      logic [1:0] seq [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
      test_reset(1'b1);
      step(50, 50, 0);
      for (int i = 0; i < 8; i++)
         frame(seq[i]);
   endtask

   task automatic test_request;
      test_reset(1'b0);
      step(50, 50, 0);
      step(0, 0, 0);
      chk_ready("req_pre", 1'b1);
      step(200, 100, 0, 1'b1, 2'd3);
      chk_ready("req_drop", 1'b0);
      step(320, 240, 0);
      step(639, 479, 0);
      step(0, 0, 3);
      chk_ready("req_back", 1'b1);
      step(5, 5, 3);
      step(32, 5, 3);
   endtask

   task automatic test_priority;
      test_reset(1'b1);
      step(50, 50, 0);
      step(0, 0, 0);
      step(200, 100, 0, 1'b1, 2'd2);
      step(320, 240, 0);
      frame(2);
      chk_ready("prio_back", 1'b1);
      frame(2);
      frame(3);
   endtask

   task automatic test_boundary_req;
      test_reset(1'b0);
      step(50, 50, 0);
      step(0, 0, 0, 1'b1, 2'd3);
      chk_ready("bnd_drop", 1'b0);
      step(320, 240, 0);
      step(0, 0, 3);
      step(5, 5, 3);
   endtask

   task automatic test_bars;
      int xs [6] = '{0, 79, 80, 559, 560, 639};
      test_reset(1'b0);
      step(50, 50, 0);
      step(0, 0, 0);
      step(200, 100, 0, 1'b1, 2'd2);
      step(0, 0, 2);
      for (int i = 0; i < 6; i++)
         step(xs[i], 10, 2);
   endtask

   task automatic test_reset_pending;
      test_reset(1'b0);
      step(50, 50, 0);
      step(0, 0, 0);
      step(200, 100, 0, 1'b1, 2'd1);
      chk_ready("rp_drop", 1'b0);
      @(negedge clk);
      rst = 1'b1;
      sx = 10'd300;
      sy = 10'd100;
      @(posedge clk);
      #1;
      checks++;
      if (scene !== 2'd0 || req_ready !== 1'b1 || rgb !== 24'h0) begin
         failures++;
         $display("FAIL rst_pending scene=%0d rdy=%b rgb=%h exp 0,1,0",
                  scene, req_ready, rgb);
      end
      @(negedge clk);
      rst = 1'b0;
      step(320, 240, 0);
      step(0, 0, 0);
      step(150, 150, 0);
      chk_ready("rp_after", 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      sx = 10'd0;
      sy = 10'd0;
      auto_en = 1'b0;
      req_valid = 1'b0;
      req_scene = 2'd0;
      test_static;
      test_auto;
      test_request;
      test_priority;
      test_boundary_req;
      test_bars;
      test_reset_pending;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
